// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared op-code constants, state encoding and width defaults for
//             the ALU control decoder and the multi-cycle execution unit.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_DATA_WIDTH  = 32;
    localparam int ALU_SHAMT_WIDTH = 5;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_LUI = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_comb_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_comb_core
//  Purpose  : Purely combinational ADD/SUB/LUI/OR datapath. With the
//             ALU_BARREL_SHIFT_EN macro defined, SLL is a full barrel shift.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = ALU_DATA_WIDTH,
    parameter int SHAMT_WIDTH = ALU_SHAMT_WIDTH
) (
    input  logic [3:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_result
);

    logic [SHAMT_WIDTH-1:0] w_shamt;

    assign w_shamt = i_b[SHAMT_WIDTH-1:0];

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a + ~i_b + DATA_WIDTH'(1);
            ALU_LUI: o_result = i_b;
            ALU_OR:  o_result = i_a | i_b;
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL: o_result = i_a << w_shamt;
`else
            // Only the shamt==0 case reaches this path; longer shifts iterate.
            ALU_SLL: o_result = i_a;
`endif
            default: o_result = '0;
        endcase
    end

`ifndef ALU_BARREL_SHIFT_EN
    logic w_unused_shamt;
    assign w_unused_shamt = ^w_shamt;
`endif

endmodule : alu_comb_core
`default_nettype wire

// File: rtl/alu_multicycle_exec.sv
`default_nettype none
// ============================================================================
//  Module   : alu_multicycle_exec
//  Purpose  : Start/ready/done execution unit; single-cycle ALU ops plus an
//             iterative one-bit-per-cycle SLL. Defining ALU_BARREL_SHIFT_EN
//             makes SLL single-cycle and removes the SHIFT state and counter.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_multicycle_exec
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = ALU_DATA_WIDTH,
    parameter int SHAMT_WIDTH = ALU_SHAMT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o
);

    logic [DATA_WIDTH-1:0] w_core_result;
    logic                  w_accept;

    logic [DATA_WIDTH-1:0] r_result_q, r_result_d;
    logic                  r_zero_q,   r_zero_d;
    logic                  r_done_q,   r_done_d;

    alu_comb_core #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_core (
        .i_op     (ALU_Operation_i),
        .i_a      (A_i),
        .i_b      (B_i),
        .o_result (w_core_result)
    );

    assign w_accept = start_i && ready_o;

`ifdef ALU_BARREL_SHIFT_EN

    assign ready_o = 1'b1;

    always_comb begin
        r_result_d = r_result_q;
        r_zero_d   = r_zero_q;
        r_done_d   = 1'b0;
        if (w_accept) begin
            r_result_d = w_core_result;
            r_zero_d   = (w_core_result == '0);
            r_done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result_q <= '0;
            r_zero_q   <= 1'b1;
            r_done_q   <= 1'b0;
        end else begin
            r_result_q <= r_result_d;
            r_zero_q   <= r_zero_d;
            r_done_q   <= r_done_d;
        end
    end

`else

    alu_state_e             r_state_q, r_state_d;
    logic [DATA_WIDTH-1:0]  r_acc_q,   r_acc_d;
    logic [SHAMT_WIDTH-1:0] r_cnt_q,   r_cnt_d;
    logic [SHAMT_WIDTH-1:0] w_shamt;
    logic                   w_iter_sll;
    logic [DATA_WIDTH-1:0]  w_acc_shl;

    assign w_shamt    = B_i[SHAMT_WIDTH-1:0];
    assign w_iter_sll = (ALU_Operation_i == ALU_SLL) && (w_shamt != '0);
    assign w_acc_shl  = r_acc_q << 1;
    assign ready_o    = (r_state_q == ST_IDLE);

    always_comb begin
        r_state_d  = r_state_q;
        r_acc_d    = r_acc_q;
        r_cnt_d    = r_cnt_q;
        r_result_d = r_result_q;
        r_zero_d   = r_zero_q;
        r_done_d   = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_iter_sll) begin
                        r_acc_d   = A_i;
                        r_cnt_d   = w_shamt;
                        r_state_d = ST_SHIFT;
                    end else begin
                        r_result_d = w_core_result;
                        r_zero_d   = (w_core_result == '0);
                        r_done_d   = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                r_acc_d = w_acc_shl;
                r_cnt_d = r_cnt_q - SHAMT_WIDTH'(1);
                // Last shift writes the result directly so done lands n edges after accept.
                if (r_cnt_q == SHAMT_WIDTH'(1)) begin
                    r_result_d = w_acc_shl;
                    r_zero_d   = (w_acc_shl == '0);
                    r_done_d   = 1'b1;
                    r_state_d  = ST_IDLE;
                end
            end
            default: r_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= ST_IDLE;
            r_acc_q    <= '0;
            r_cnt_q    <= '0;
            r_result_q <= '0;
            r_zero_q   <= 1'b1;
            r_done_q   <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            r_acc_q    <= r_acc_d;
            r_cnt_q    <= r_cnt_d;
            r_result_q <= r_result_d;
            r_zero_q   <= r_zero_d;
            r_done_q   <= r_done_d;
        end
    end

`endif

    assign done_o   = r_done_q;
    assign result_o = r_result_q;
    assign zero_o   = r_zero_q;

endmodule : alu_multicycle_exec
`default_nettype wire

// File: tb/tb_alu_multicycle_exec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_multicycle_exec
//  Purpose  : Directed, table-driven self-checking bench for alu_multicycle_exec
//             (honours ALU_BARREL_SHIFT_EN for the SLL latency expectations).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle_exec;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [3:0]  ALU_Operation_i;
    logic [31:0] A_i;
    logic [31:0] B_i;
    logic        ready_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        zero_o;

    int n_pass;
    int n_total;

`ifdef ALU_BARREL_SHIFT_EN
    localparam int LAT31 = 0;
    localparam int LAT4  = 0;
`else
    localparam int LAT31 = 31;
    localparam int LAT4  = 4;
`endif

    alu_multicycle_exec #(
        .DATA_WIDTH  (32),
        .SHAMT_WIDTH (5)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .ALU_Operation_i (ALU_Operation_i),
        .A_i             (A_i),
        .B_i             (B_i),
        .ready_o         (ready_o),
        .done_o          (done_o),
        .result_o        (result_o),
        .zero_o          (zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
    } vec_t;

    vec_t vecs [10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start_i         = s;
        ALU_Operation_i = op;
        A_i             = a;
        B_i             = b;
    endtask

    initial begin
        int e;
        int rdy_low;
        int pulses;

        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        drive(1'b0, 4'h0, 32'h0, 32'h0);

        vecs[0] = '{4'b0000, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 1'b1};
        vecs[1] = '{4'b0001, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0};
        vecs[2] = '{4'b1111, 32'h0000_0007, 32'h0000_0009, 32'h0000_0000, 1'b1};
        vecs[3] = '{4'b0011, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0};
        vecs[4] = '{4'b0010, 32'hAAAA_AAAA, 32'h1234_5000, 32'h1234_5000, 1'b0};
        vecs[5] = '{4'b0100, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 32'hDEAD_BEEF, 1'b0};
        vecs[6] = '{4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
        vecs[7] = '{4'b0101, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[8] = '{4'b0001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1};
        vecs[9] = '{4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};

        // Reset held two cycles
        step();
        step();
        reset = 1'b0;
        chk("rst_ready",  32'(ready_o),  32'h1);
        chk("rst_done",   32'(done_o),   32'h0);
        chk("rst_result", result_o,      32'h0);
        chk("rst_zero",   32'(zero_o),   32'h1);
        step();

        // Single-cycle vector table
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            step();
            drive(1'b0, 4'h0, 32'h0, 32'h0);
            chk($sformatf("vec%0d_done", i),   32'(done_o), 32'h1);
            chk($sformatf("vec%0d_result", i), result_o,    vecs[i].res);
            chk($sformatf("vec%0d_zero", i),   32'(zero_o), 32'(vecs[i].z));
            step();
            chk($sformatf("vec%0d_done_drop", i), 32'(done_o), 32'h0);
        end

        // Back-to-back OR then LUI
        drive(1'b1, 4'b0011, 32'hF0F0_0000, 32'h0000_0F0F);
        step();
        chk("b2b_or_done",   32'(done_o), 32'h1);
        chk("b2b_or_result", result_o,    32'hF0F0_0F0F);
        drive(1'b1, 4'b0010, 32'h0, 32'h1234_5000);
        step();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        chk("b2b_lui_done",   32'(done_o), 32'h1);
        chk("b2b_lui_result", result_o,    32'h1234_5000);
        step();
        chk("b2b_done_drop", 32'(done_o), 32'h0);

        // SLL A=1 shamt=31, with an ignored start mid-shift
        drive(1'b1, 4'b0100, 32'h0000_0001, 32'h0000_001F);
        step();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        e = 0;
        rdy_low = 0;
        while (!done_o && e < 40) begin
            if (!ready_o) rdy_low++;
            if (e == 5) drive(1'b1, 4'b0000, 32'h0, 32'h0);
            step();
            if (e == 5) drive(1'b0, 4'h0, 32'h0, 32'h0);
            e++;
        end
        chk("sll31_latency",  32'(e),       32'(LAT31));
        chk("sll31_rdy_low",  32'(rdy_low), 32'(LAT31));
        chk("sll31_done",     32'(done_o),  32'h1);
        chk("sll31_result",   result_o,     32'h8000_0000);
        chk("sll31_zero",     32'(zero_o),  32'h0);
        step();
        chk("sll31_no_queue", 32'(done_o),  32'h0);
        chk("sll31_hold",     result_o,     32'h8000_0000);

        // SLL shamt=4, new start accepted in the completion cycle
        drive(1'b1, 4'b0100, 32'h0000_000F, 32'h0000_0004);
        step();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        e = 0;
        while (!done_o && e < 10) begin
            step();
            e++;
        end
        chk("sll4_latency", 32'(e),       32'(LAT4));
        chk("sll4_result",  result_o,     32'h0000_00F0);
        chk("sll4_ready",   32'(ready_o), 32'h1);
        drive(1'b1, 4'b0000, 32'h0000_0010, 32'h0000_0020);
        step();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        chk("chain_done",   32'(done_o), 32'h1);
        chk("chain_result", result_o,    32'h0000_0030);
        step();

        // Reset in the middle of an SLL shamt=20
        drive(1'b1, 4'b0100, 32'h0000_0003, 32'h0000_0014);
        step();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        for (int k = 0; k < 5; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_ready",  32'(ready_o), 32'h1);
        chk("mid_rst_done",   32'(done_o),  32'h0);
        chk("mid_rst_result", result_o,     32'h0);
        chk("mid_rst_zero",   32'(zero_o),  32'h1);
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (done_o) pulses++;
        end
        chk("mid_rst_no_pulse", 32'(pulses), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_alu_multicycle_exec
`default_nettype wire
